keypad_encoder_param: RTL and testbench

//   Parametrised keypad encoder. Turns a one-hot keypad vector into a binary

---
 rtl/keypad_encoder_param.sv | 181 ++++++++++++++++++
 tb/tb_keypad_encoder_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder_param.sv
// -----------------------------------------------------------------------------
// keypad_encoder_param
//   Turns a one-hot keypad vector into a binary digit code and emits one
//   active-low load strobe per debounced press. Presses and releases are both
//   debounced, presses of more than one key are rejected until everything is
//   released, and a free-running divider produces the pgt_1Hz square wave.
//
// Ports
//   Hz_100_clock  in   1         sole clock, rising edge
//   reset         in   1         synchronous reset, active-high
//   enablen       in   1         active-low enable for accepting new presses
//   teclado       in   NUM_KEYS  keypad lines, bit i high = key i pressed
//   D             out  CODE_W    code of the last accepted key, held
//   loadn         out  1         active-low load strobe, one cycle per press
//   pgt_1Hz       out  1         50% square wave, period PGT_DIV cycles
//   multi_err     out  1         high while a multi-key press awaits release
// -----------------------------------------------------------------------------
module keypad_encoder_param #(
   parameter int NUM_KEYS       = 10,
   parameter int CODE_W         = 4,
   parameter int DEBOUNCE_TICKS = 3,
   parameter int PGT_DIV        = 100
) (
   input  logic                Hz_100_clock,
   input  logic                reset,
   input  logic                enablen,
   input  logic [NUM_KEYS-1:0] teclado,
   output logic [CODE_W-1:0]   D,
   output logic                loadn,
   output logic                pgt_1Hz,
   output logic                multi_err
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, LOAD, WAIT_REL} state_t;

   // The sample counter holds "samples seen so far", so the decision to leave
   // DEBOUNCE / WAIT_REL is taken when it already holds DEBOUNCE_TICKS-1 and
   // the current sample completes the run.
   localparam int                CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   localparam int                HALF     = PGT_DIV / 2;
   localparam int                DIV_W    = $clog2(HALF + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [NUM_KEYS-1:0] pattern, pattern_n;
   logic [CODE_W-1:0]   index, index_n;
   logic [CODE_W-1:0]   d_n;
   logic                loadn_n;
   logic                multi_err_n;

   logic [CODE_W-1:0]   key_idx;
   logic                any_key;
   logic                one_hot;
   logic                multi_key;

   logic [DIV_W-1:0]    div_cnt;

   // Key classification on the raw sample.
   assign any_key   = |teclado;
   assign one_hot   = any_key && ((teclado & (teclado - NUM_KEYS'(1))) == '0);
   assign multi_key = any_key && !one_hot;

   // Index of the set bit; only meaningful when one_hot is true.
   always_comb begin
      key_idx = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (teclado[i]) key_idx = CODE_W'(i);
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_n     = state;
      cnt_n       = cnt;
      pattern_n   = pattern;
      index_n     = index;
      d_n         = D;
      loadn_n     = 1'b1;
      multi_err_n = multi_err;

      unique case (state)
         IDLE: begin
            if (!enablen) begin
               if (one_hot) begin
                  pattern_n = teclado;
                  index_n   = key_idx;
                  if (DEBOUNCE_TICKS == 1) begin
                     // A single sample is already a full run.
                     d_n     = key_idx;
                     loadn_n = 1'b0;
                     state_n = LOAD;
                  end else begin
                     cnt_n   = CNT_W'(1);
                     state_n = DEBOUNCE;
                  end
               end else if (multi_key) begin
                  multi_err_n = 1'b1;
                  cnt_n       = '0;
                  state_n     = WAIT_REL;
               end
            end
         end

         DEBOUNCE: begin
            if (enablen || (teclado != pattern)) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else if (cnt == CNT_LAST) begin
               // Strobe and code are registered on entry to LOAD, so loadn is
               // low exactly while the FSM sits in LOAD.
               d_n     = index;
               loadn_n = 1'b0;
               state_n = LOAD;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end

         LOAD: begin
            cnt_n   = '0;
            state_n = WAIT_REL;
         end

         WAIT_REL: begin
            if (any_key) begin
               cnt_n = '0;
            end else if (cnt == CNT_LAST) begin
               cnt_n       = '0;
               multi_err_n = 1'b0;
               state_n     = IDLE;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end

         default: state_n = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge Hz_100_clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         pattern   <= '0;
         index     <= '0;
         D         <= '0;
         loadn     <= 1'b1;
         multi_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         pattern   <= pattern_n;
         index     <= index_n;
         D         <= d_n;
         loadn     <= loadn_n;
         multi_err <= multi_err_n;
      end
   end

   // Free-running divider, independent of enablen and the FSM.
   always_ff @(posedge Hz_100_clock) begin
      if (reset) begin
         div_cnt <= '0;
         pgt_1Hz <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         pgt_1Hz <= ~pgt_1Hz;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: tb/tb_keypad_encoder_param.sv
// -----------------------------------------------------------------------------
// tb_keypad_encoder_param
//   Self-checking bench for keypad_encoder_param with default parameters
//   (10 keys, 4-bit code, 3-sample debounce, divide-by-100 pgt_1Hz).
//   A table of per-cycle vectors gives the inputs for one clock edge and the
//   outputs expected right after it. Every expected strobe is also pushed to a
//   scoreboard queue that a monitor pops whenever loadn is seen low.
// -----------------------------------------------------------------------------
module tb_keypad_encoder_param;

   logic       clk;
   logic       reset;
   logic       enablen;
   logic [9:0] teclado;
   logic [3:0] D;
   logic       loadn;
   logic       pgt_1Hz;
   logic       multi_err;

   int checks   = 0;
   int failures = 0;

   keypad_encoder_param #(
      .NUM_KEYS       (10),
      .CODE_W         (4),
      .DEBOUNCE_TICKS (3),
      .PGT_DIV        (100)
   ) dut (
      .Hz_100_clock (clk),
      .reset        (reset),
      .enablen      (enablen),
      .teclado      (teclado),
      .D            (D),
      .loadn        (loadn),
      .pgt_1Hz      (pgt_1Hz),
      .multi_err    (multi_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       en_n;
      logic [9:0] keys;
      logic       exp_loadn;
      logic [3:0] exp_d;
      logic       exp_merr;
   } vec_t;

   vec_t       vecs[$];
   logic [3:0] sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] k(input int i);
      logic [9:0] one;
      one = 10'd1;
      return one << i;
   endfunction

   task automatic add(input logic rst, input logic en_n, input logic [9:0] keys,
                      input logic exp_loadn, input logic [3:0] exp_d, input logic exp_merr,
                      input int reps);
      vec_t v;
      for (int r = 0; r < reps; r++) begin
         v.rst = rst; v.en_n = en_n; v.keys = keys;
         v.exp_loadn = exp_loadn; v.exp_d = exp_d; v.exp_merr = exp_merr;
         vecs.push_back(v);
      end
   endtask

   // Scoreboard monitor: every observed strobe must match the oldest expected one.
   always @(negedge clk) begin
      if (loadn === 1'b0) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_strobe", {28'd0, D}, 32'hFFFF_FFFF);
         end else begin
            check("sb_strobe_code", {28'd0, D}, {28'd0, sb_q.pop_front()});
         end
      end
   end

   // Counts edges until pgt_1Hz changes, bounded to 200 cycles.
   task automatic measure_half(output int n, output bit ok);
      logic prev;
      prev = pgt_1Hz;
      n    = 0;
      ok   = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         n++;
         if (pgt_1Hz !== prev) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int  n;
      bit  ok;
      logic lvl;

      reset   = 1'b1;
      enablen = 1'b1;
      teclado = '0;

      // ---- vector table: rst, en_n, keys, exp_loadn, exp_d, exp_merr, reps ----
      // Reset state.
      add(1, 1, '0,   1, 0, 0, 2);
      // Key 5 held: strobe on the third sample only, none while held.
      add(0, 0, k(5), 1, 0, 0, 2);
      add(0, 0, k(5), 0, 5, 0, 1);
      add(0, 0, k(5), 1, 5, 0, 7);
      add(0, 0, '0,   1, 5, 0, 3);
      // Key 7 bounce: 2 samples, gap, then a clean run of 4.
      add(0, 0, k(7), 1, 5, 0, 2);
      add(0, 0, '0,   1, 5, 0, 1);
      add(0, 0, k(7), 1, 5, 0, 2);
      add(0, 0, k(7), 0, 7, 0, 1);
      add(0, 0, k(7), 1, 7, 0, 1);
      add(0, 0, '0,   1, 7, 0, 3);
      // Two keys: error flag until three zero samples, code untouched.
      add(0, 0, 10'b0000010010, 1, 7, 1, 1);
      add(0, 0, '0,             1, 7, 1, 2);
      add(0, 0, '0,             1, 7, 0, 1);
      // Bouncing release of a multi-key press restarts the zero count.
      add(0, 0, 10'b0000010010, 1, 7, 1, 2);
      add(0, 0, '0,             1, 7, 1, 1);
      add(0, 0, 10'b0000010010, 1, 7, 1, 1);
      add(0, 0, '0,             1, 7, 1, 2);
      add(0, 0, '0,             1, 7, 0, 1);
      // Key 3 loads after the error clears.
      add(0, 0, k(3), 1, 7, 0, 2);
      add(0, 0, k(3), 0, 3, 0, 1);
      add(0, 0, k(3), 1, 3, 0, 1);
      add(0, 0, '0,   1, 3, 0, 3);
      // Disabled: multi-key and key 9 are both ignored.
      add(0, 1, 10'b0000000011, 1, 3, 0, 1);
      add(0, 1, k(9), 1, 3, 0, 10);
      add(0, 1, '0,   1, 3, 0, 1);
      // enablen raised mid-debounce aborts; a fresh run then loads key 6.
      add(0, 0, k(6), 1, 3, 0, 1);
      add(0, 1, k(6), 1, 3, 0, 1);
      add(0, 0, k(6), 1, 3, 0, 2);
      add(0, 0, k(6), 0, 6, 0, 1);
      add(0, 1, k(6), 1, 6, 0, 1);
      // Release completes even with enablen high; key 4 then loads.
      add(0, 1, '0,   1, 6, 0, 3);
      add(0, 0, k(4), 1, 6, 0, 2);
      add(0, 0, k(4), 0, 4, 0, 1);
      add(0, 0, k(4), 1, 4, 0, 1);
      add(0, 0, '0,   1, 4, 0, 3);
      // Key changes during debounce: restart on the new key (9).
      add(0, 0, k(1), 1, 4, 0, 1);
      add(0, 0, k(9), 1, 4, 0, 3);
      add(0, 0, k(9), 0, 9, 0, 1);
      // Sample during LOAD is not part of the release run: 4 zeros needed.
      add(0, 0, '0,   1, 9, 0, 4);
      // Reset mid-debounce with key 2 held, then key 2 loads after release of reset.
      add(0, 0, k(2), 1, 9, 0, 2);
      add(1, 0, k(2), 1, 0, 0, 2);
      add(0, 0, k(2), 1, 0, 0, 2);
      add(0, 0, k(2), 0, 2, 0, 1);
      add(0, 0, k(2), 1, 2, 0, 1);
      add(0, 0, '0,   1, 2, 0, 3);
      // Reset on the edge that would enter LOAD suppresses the strobe.
      add(0, 0, k(8), 1, 2, 0, 2);
      add(1, 0, k(8), 1, 0, 0, 1);
      add(0, 0, k(8), 1, 0, 0, 2);
      add(0, 0, k(8), 0, 8, 0, 1);
      add(0, 0, k(8), 1, 8, 0, 1);
      add(0, 0, '0,   1, 8, 0, 3);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset   = vecs[i].rst;
         enablen = vecs[i].en_n;
         teclado = vecs[i].keys;
         if (vecs[i].exp_loadn == 1'b0) sb_q.push_back(vecs[i].exp_d);
         @(posedge clk); #1;
         check($sformatf("v%0d_loadn", i), {31'd0, loadn},     {31'd0, vecs[i].exp_loadn});
         check($sformatf("v%0d_D", i),     {28'd0, D},         {28'd0, vecs[i].exp_d});
         check($sformatf("v%0d_merr", i),  {31'd0, multi_err}, {31'd0, vecs[i].exp_merr});
         if (vecs[i].rst) check($sformatf("v%0d_pgt_reset", i), {31'd0, pgt_1Hz}, 32'd0);
      end

      // Let the monitor see the final cycle, then every expected strobe must be consumed.
      @(negedge clk);
      check("sb_pending", sb_q.size(), 32'd0);

      // ---- pgt_1Hz: 50 cycles per half period, running with enablen high ----
      enablen = 1'b1;
      teclado = k(9);
      measure_half(n, ok);
      check("pgt_align_seen", {31'd0, ok}, 32'd1);
      for (int h = 0; h < 4; h++) begin
         lvl = pgt_1Hz;
         measure_half(n, ok);
         check($sformatf("pgt_half%0d_lvl%0d_cycles", h, lvl), n, 32'd50);
      end
      check("pgt_no_strobe_loadn", {31'd0, loadn}, 32'd1);

      // ---- pgt_1Hz restarts from 0 after reset: first toggle 50 edges later ----
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("pgt_after_reset", {31'd0, pgt_1Hz}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      measure_half(n, ok);
      check("pgt_first_half_cycles", n, 32'd50);
      check("pgt_first_half_level", {31'd0, pgt_1Hz}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
